// File: rtl/lc3b_types.sv
// Shared LC-3b fetch types: machine word, fetch-queue entry and fetch FSM state.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        lc3b_word pc;
        lc3b_word instr;
    } lc3b_fetch_entry;

    typedef enum logic [0:0] {
        StIdle,
        StReq
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two FIFO for fetched instructions; synchronous flush overrides enq/deq.
// Enqueue while full is accepted only when a dequeue happens in the same cycle.
module fetch_fifo
    import lc3b_types::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = lc3b_fetch_entry
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   enq,
    input  entry_t enq_data,
    input  logic   deq,
    output entry_t head,
    output logic   empty,
    output logic   full
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    entry_t          mem_q [DEPTH];
    logic            do_enq, do_deq;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CntW'(DEPTH));
    assign head   = mem_q[rd_ptr_q];
    assign do_deq = deq && !empty;
    assign do_enq = enq && (!full || do_deq);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_deq) rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (!flush && do_enq) mem_q[wr_ptr_q] <= enq_data;
        end
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// Queued fetch stage with a one-line buffer and request/response imem handshake.
// Define FETCH_QUEUE_BYPASS_EN to let a hit on an empty queue drive out_* in the same cycle.
module fetch_queue_stage
    import lc3b_types::*;
#(
    parameter int unsigned LINE_BYTES  = 16,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_read,
    output logic [15:0]             imem_address,
    input  logic                    imem_resp,
    input  logic [LINE_BYTES*8-1:0] imem_rdata,
    input  logic                    branch_enable,
    input  logic [15:0]             new_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             out_instr,
    output logic [15:0]             out_pc,
    output logic [15:0]             out_pc_plus2
);

    localparam int unsigned OffW  = $clog2(LINE_BYTES);
    localparam int unsigned Words = LINE_BYTES / 2;
    localparam int unsigned TagW  = 16 - OffW;

    fetch_state_e            state_q, state_d;
    lc3b_word                pc_q, pc_d;
    lc3b_word                addr_q, addr_d;
    logic                    read_q, read_d;
    logic                    squash_q, squash_d;
    logic [LINE_BYTES*8-1:0] line_q, line_d;
    logic [TagW-1:0]         line_tag_q, line_tag_d;
    logic                    line_valid_q, line_valid_d;

    lc3b_word        line_words [Words];
    lc3b_word        fetch_word;
    lc3b_fetch_entry fetch_entry, fifo_head;
    logic            hit, can_accept, fetch_go;
    logic            fifo_enq, fifo_deq, fifo_empty, fifo_full;

    for (genvar g = 0; g < Words; g++) begin : g_words
        assign line_words[g] = line_q[g*16 +: 16];
    end

    if (Words > 1) begin : g_sel
        assign fetch_word = line_words[pc_q[OffW-1:1]];
    end else begin : g_sel_one
        assign fetch_word = line_words[0];
    end

    assign hit         = line_valid_q && (line_tag_q == pc_q[15:OffW]);
    assign fifo_deq    = out_ready && !fifo_empty;
    assign can_accept  = !fifo_full || fifo_deq;
    assign fetch_go    = (state_q == StIdle) && hit && !branch_enable && can_accept;
    assign fetch_entry = '{pc: pc_q, instr: fetch_word};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        read_d       = read_q;
        squash_d     = squash_q;
        line_d       = line_q;
        line_tag_d   = line_tag_q;
        line_valid_d = line_valid_q;
        if (branch_enable) begin
            pc_d = new_pc;
            // An issued request cannot be withdrawn; remember to drop its data.
            if (state_q == StReq) begin
                if (imem_resp) begin
                    state_d  = StIdle;
                    read_d   = 1'b0;
                    squash_d = 1'b0;
                end else begin
                    squash_d = 1'b1;
                end
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hit) begin
                        if (fetch_go) pc_d = pc_q + 16'd2;
                    end else if (can_accept) begin
                        state_d = StReq;
                        read_d  = 1'b1;
                        addr_d  = {pc_q[15:OffW], {OffW{1'b0}}};
                    end
                end
                StReq: begin
                    if (imem_resp) begin
                        state_d = StIdle;
                        read_d  = 1'b0;
                        if (squash_q) begin
                            squash_d = 1'b0;
                        end else begin
                            line_d       = imem_rdata;
                            line_tag_d   = addr_q[15:OffW];
                            line_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            addr_q       <= '0;
            read_q       <= 1'b0;
            squash_q     <= 1'b0;
            line_q       <= '0;
            line_tag_q   <= '0;
            line_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            read_q       <= read_d;
            squash_q     <= squash_d;
            line_q       <= line_d;
            line_tag_q   <= line_tag_d;
            line_valid_q <= line_valid_d;
        end
    end

    assign imem_read    = read_q;
    assign imem_address = addr_q;

    fetch_fifo #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (lc3b_fetch_entry)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (branch_enable),
        .enq      (fifo_enq),
        .enq_data (fetch_entry),
        .deq      (fifo_deq),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass   = fifo_empty && (state_q == StIdle) && hit && !branch_enable;
    assign fifo_enq = fetch_go && !(bypass && out_ready);

    always_comb begin
        if (bypass) begin
            out_valid = 1'b1;
            out_pc    = pc_q;
            out_instr = fetch_word;
        end else begin
            out_valid = !fifo_empty;
            out_pc    = fifo_head.pc;
            out_instr = fifo_head.instr;
        end
    end
`else
    assign fifo_enq  = fetch_go;
    assign out_valid = !fifo_empty;
    assign out_pc    = fifo_head.pc;
    assign out_instr = fifo_head.instr;
`endif

    assign out_pc_plus2 = out_pc + 16'd2;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage; memory word at pc holds 0x1000 + pc/2.
module tb_fetch_queue_stage;

    localparam int unsigned LB = 16;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam logic ExpByp = 1'b1;
`else
    localparam logic ExpByp = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, imem_read, imem_resp, branch_enable, out_valid, out_ready;
    logic [15:0]     imem_address, new_pc, out_instr, out_pc, out_pc_plus2;
    logic [LB*8-1:0] imem_rdata;

    fetch_queue_stage #(
        .LINE_BYTES  (LB),
        .QUEUE_DEPTH (4),
        .RESET_PC    (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_read     (imem_read),
        .imem_address  (imem_address),
        .imem_resp     (imem_resp),
        .imem_rdata    (imem_rdata),
        .branch_enable (branch_enable),
        .new_pc        (new_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_pc_plus2  (out_pc_plus2)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wait_cnt = 0;
    int          resp_lat = 3;
    logic        prev_read = 1'b0;
    logic [15:0] req_addr [$];
    logic [15:0] x_pc [$];
    logic [15:0] x_ins [$];
    logic [15:0] x_p2 [$];
    int          x_cyc [$];

    function automatic logic [15:0] mem_word(input logic [15:0] pc);
        return 16'h1000 + {1'b0, pc[15:1]};
    endfunction

    function automatic logic [LB*8-1:0] mk_line(input logic [15:0] a);
        logic [LB*8-1:0] l;
        for (int i = 0; i < int'(LB / 2); i++) l[i*16 +: 16] = mem_word(a + 16'(2 * i));
        return l;
    endfunction

    // One clock: log the handshake seen before the edge, then play the memory after it.
    task automatic tick();
        if (!rst && out_valid && out_ready) begin
            x_pc.push_back(out_pc);
            x_ins.push_back(out_instr);
            x_p2.push_back(out_pc_plus2);
            x_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (imem_read && !prev_read) req_addr.push_back(imem_address);
        prev_read = imem_read;
        imem_resp = 1'b0;
        if (imem_read && !rst) begin
            wait_cnt++;
            if (wait_cnt >= resp_lat) begin
                imem_resp  = 1'b1;
                imem_rdata = mk_line(imem_address);
                wait_cnt   = 0;
            end
        end else begin
            wait_cnt = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        branch_enable = 1'b0;
        out_ready = 1'b0;
        imem_resp = 1'b0;
        tick();
        tick();
        x_pc.delete();
        x_ins.delete();
        x_p2.delete();
        x_cyc.delete();
        req_addr.delete();
        prev_read = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5 && !imem_read; i++) tick();
        checks++;
        if (imem_read !== 1'b1 || imem_address !== 16'h0000) begin
            errors++;
            $display("FAIL first_req: read=%b addr=%h want 1/0000", imem_read, imem_address);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (imem_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_read: got %b want 0", imem_read);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        checks++;
        if (imem_address !== 16'h0000 || out_pc !== 16'h0000 || out_instr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: addr=%h pc=%h instr=%h want 0", imem_address, out_pc,
                     out_instr);
        end
        // A stray response while IDLE must not load the line buffer.
        rst = 1'b0;
        prev_read = 1'b0;
        imem_resp = 1'b1;
        imem_rdata = mk_line(16'h0000);
        tick();
        checks++;
        if (imem_read !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_resp: read=%b valid=%b want 1/0", imem_read, out_valid);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 60 && x_pc.size() < 8; i++) tick();
        tick();
        tick();
        checks++;
        if (x_pc.size() != 8) begin
            errors++;
            $display("FAIL seq_count: got %0d want 8", x_pc.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < x_pc.size()) begin
                checks++;
                if (x_pc[i] !== 16'(2 * i) || x_ins[i] !== 16'h1000 + 16'(i)) begin
                    errors++;
                    $display("FAIL seq_word%0d: pc=%h instr=%h want %h/%h", i, x_pc[i], x_ins[i],
                             16'(2 * i), 16'h1000 + 16'(i));
                end
            end
        end
        checks++;
        if (x_cyc.size() != 8 || x_cyc[7] - x_cyc[0] != 7) begin
            errors++;
            $display("FAIL seq_stream: %0d words not back to back", x_cyc.size());
        end
        checks++;
        if (req_addr.size() != 2 || req_addr[0] !== 16'h0000 || req_addr[1] !== 16'h0010) begin
            errors++;
            $display("FAIL seq_reqs: count=%0d want 2 (0000 then 0010)", req_addr.size());
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 30; i++) tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_instr !== 16'h1000) begin
            errors++;
            $display("FAIL full_head: valid=%b pc=%h instr=%h want 1/0000/1000", out_valid,
                     out_pc, out_instr);
        end
        checks++;
        if (req_addr.size() != 1) begin
            errors++;
            $display("FAIL full_reqs: got %0d want 1", req_addr.size());
        end
        out_ready = 1'b1;
        for (int i = 0; i < 40 && x_pc.size() < 8; i++) tick();
        checks++;
        if (x_pc.size() != 8 || x_cyc[7] - x_cyc[0] != 7) begin
            errors++;
            $display("FAIL full_drain: %0d words, not back to back", x_pc.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < x_pc.size()) begin
                checks++;
                if (x_pc[i] !== 16'(2 * i) || x_ins[i] !== 16'h1000 + 16'(i)) begin
                    errors++;
                    $display("FAIL full_word%0d: pc=%h instr=%h", i, x_pc[i], x_ins[i]);
                end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 60 && req_addr.size() < 2; i++) tick();
        checks++;
        if (req_addr.size() != 2 || req_addr[1] !== 16'h0010) begin
            errors++;
            $display("FAIL redir_setup: %0d requests, want 2nd at 0010", req_addr.size());
        end
        branch_enable = 1'b1;
        new_pc = 16'h0046;
        tick();
        branch_enable = 1'b0;
        x_pc.delete();
        x_ins.delete();
        checks++;
        if (out_valid !== 1'b0 || imem_read !== 1'b1 || imem_address !== 16'h0010) begin
            errors++;
            $display("FAIL redir_hold: valid=%b read=%b addr=%h want 0/1/0010", out_valid,
                     imem_read, imem_address);
        end
        for (int i = 0; i < 40 && x_pc.size() < 1; i++) tick();
        checks++;
        if (x_pc.size() < 1 || x_pc[0] !== 16'h0046 || x_ins[0] !== 16'h1023) begin
            errors++;
            $display("FAIL redir_first: got %0d words, first pc=%h want 0046/1023", x_pc.size(),
                     (x_pc.size() > 0) ? x_pc[0] : 16'hxxxx);
        end
        checks++;
        if (req_addr.size() != 3 || req_addr[2] !== 16'h0040) begin
            errors++;
            $display("FAIL redir_req: count=%0d want 3, last at 0040", req_addr.size());
        end
        // Redirect into the line being fetched: the squashed data must not be used.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5 && req_addr.size() < 1; i++) tick();
        branch_enable = 1'b1;
        new_pc = 16'h0004;
        tick();
        branch_enable = 1'b0;
        for (int i = 0; i < 40 && x_pc.size() < 1; i++) tick();
        checks++;
        if (x_pc.size() < 1 || x_pc[0] !== 16'h0004 || x_ins[0] !== 16'h1002) begin
            errors++;
            $display("FAIL squash_first: got %0d words, want pc 0004 instr 1002", x_pc.size());
        end
        checks++;
        if (req_addr.size() != 2 || req_addr[1] !== 16'h0000) begin
            errors++;
            $display("FAIL squash_refetch: requests=%0d want 2 (both 0000)", req_addr.size());
        end
    endtask

    task automatic test_branch_resp_same();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10 && !imem_resp; i++) tick();
        checks++;
        if (imem_resp !== 1'b1) begin
            errors++;
            $display("FAIL brs_setup: no response within budget (resp=%b)", imem_resp);
        end
        branch_enable = 1'b1;
        new_pc = 16'h0002;
        tick();
        branch_enable = 1'b0;
        checks++;
        if (imem_read !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL brs_idle: read=%b valid=%b want 0/0", imem_read, out_valid);
        end
        tick();
        checks++;
        if (imem_read !== 1'b1 || imem_address !== 16'h0000) begin
            errors++;
            $display("FAIL brs_refetch: read=%b addr=%h want 1/0000", imem_read, imem_address);
        end
        for (int i = 0; i < 40 && x_pc.size() < 1; i++) tick();
        checks++;
        if (x_pc.size() < 1 || x_pc[0] !== 16'h0002 || x_ins[0] !== 16'h1001 ||
            req_addr.size() != 2) begin
            errors++;
            $display("FAIL brs_first: words=%0d reqs=%0d want pc 0002 instr 1001, 2 reqs",
                     x_pc.size(), req_addr.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        branch_enable = 1'b1;
        new_pc = 16'hFFF0;
        tick();
        branch_enable = 1'b0;
        for (int i = 0; i < 60 && x_pc.size() < 8; i++) tick();
        tick();
        tick();
        checks++;
        if (x_pc.size() < 8 || x_pc[0] !== 16'hFFF0 || x_pc[7] !== 16'hFFFE ||
            x_ins[7] !== 16'h8FFF) begin
            errors++;
            $display("FAIL wrap_words: words=%0d want FFF0..FFFE, last instr 8FFF", x_pc.size());
        end
        checks++;
        if (x_p2.size() < 8 || x_p2[7] !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_plus2: got %h want 0000", (x_p2.size() > 7) ? x_p2[7] : 16'hxxxx);
        end
        checks++;
        if (req_addr.size() != 2 || req_addr[0] !== 16'hFFF0 || req_addr[1] !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_req: count=%0d want FFF0 then 0000", req_addr.size());
        end
    endtask

    task automatic test_hit_latency();
        do_reset();
        for (int i = 0; i < 10 && !imem_resp; i++) tick();
        tick();
        checks++;
        if (out_valid !== ExpByp) begin
            errors++;
            $display("FAIL hit_lat0: valid=%b want %b", out_valid, ExpByp);
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++;
        if (out_pc !== 16'h0000 || out_instr !== 16'h1000) begin
            errors++;
            $display("FAIL hit_bypass: pc=%h instr=%h want 0000/1000", out_pc, out_instr);
        end
`endif
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_instr !== 16'h1000) begin
            errors++;
            $display("FAIL hit_lat1: valid=%b pc=%h instr=%h want 1/0000/1000", out_valid,
                     out_pc, out_instr);
        end
    endtask

    initial begin
        rst = 1'b1;
        imem_resp = 1'b0;
        imem_rdata = '0;
        branch_enable = 1'b0;
        new_pc = 16'h0000;
        out_ready = 1'b0;
        test_reset();
        test_sequential();
        test_full();
        test_redirect();
        test_branch_resp_same();
        test_wrap();
        test_hit_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
